// File: rtl/sasc_brg_prog.sv
// Programmable baud-rate generator: divisor + fractional trim prescaler
// feeding an x4/x8/x16 oversample counter; config applied on period wrap.
//
// Ports:
//   clk, arst_n    clock, async active-low reset
//   en             enable; low clears counters (phase restart)
//   cfg_load       strobe capturing div_in/frac_in/ovs_in
//   div_in         integer divisor (tick period = div+1 clk)
//   frac_in        fractional trim, frac/2^FRAC_W clk per tick
//   ovs_in         oversample select (0=x4, 1=x8, 2/3=x16)
//   cfg_pend       captured config waiting for the next wrap
//   sio_ce_ovs     oversample-rate enable, one clk wide
//   sio_ce         bit-rate enable, coincident with sio_ce_ovs
module sasc_brg_prog #(
  parameter int DIV_W   = 16,
  parameter int FRAC_W  = 4,
  parameter int DEF_DIV = 103,
  parameter int DEF_OVS = 0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  div_in,
  input  logic [FRAC_W-1:0] frac_in,
  input  logic [1:0]        ovs_in,
  output logic              cfg_pend,
  output logic              sio_ce_ovs,
  output logic              sio_ce
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);
  localparam logic [1:0]       OVS_RST = 2'(DEF_OVS);
  localparam logic [DIV_W:0]   CNT_ONE = (DIV_W+1)'(1);

  logic [DIV_W-1:0]  div_q;
  logic [FRAC_W-1:0] frac_q;
  logic [1:0]        ovs_q;

  logic [DIV_W-1:0]  div_p;
  logic [FRAC_W-1:0] frac_p;
  logic [1:0]        ovs_p;

  logic [DIV_W-1:0]  div_n;
  logic [FRAC_W-1:0] frac_n;
  logic [1:0]        ovs_n;

  logic [DIV_W:0]    cnt;
  logic [FRAC_W-1:0] acc;
  logic [3:0]        ovs_cnt;

  logic [FRAC_W:0]   sum;
  logic              ext;
  logic [DIV_W:0]    lim;
  logic              tick;
  logic              apply;
  logic              ovs_chg;
  logic [3:0]        ovs_max;
  logic              ovs_last;

  // Carry out of the trim accumulator stretches this period by one.
  assign sum  = {1'b0, acc} + {1'b0, frac_q};
  assign ext  = sum[FRAC_W];
  assign lim  = {1'b0, div_q} + {{DIV_W{1'b0}}, ext};
  assign tick = en && (cnt == lim);

  // Config only switches on a period boundary or while idle,
  // so a running oversample period is never cut or stretched.
  assign apply = tick || !en;

  always_comb begin
    ovs_max = 4'd15;
    unique case (1'b1)
      (ovs_q == 2'd0): ovs_max = 4'd3;
      (ovs_q == 2'd1): ovs_max = 4'd7;
      default:         ovs_max = 4'd15;
    endcase
  end

  assign ovs_last = (ovs_cnt == ovs_max);

  // A strobe coinciding with the apply edge bypasses pending.
  always_comb begin
    div_n  = div_q;
    frac_n = frac_q;
    ovs_n  = ovs_q;
    if (cfg_load) begin
      div_n  = div_in;
      frac_n = frac_in;
      ovs_n  = ovs_in;
    end else if (cfg_pend) begin
      div_n  = div_p;
      frac_n = frac_p;
      ovs_n  = ovs_p;
    end
  end

  assign ovs_chg = apply && (ovs_n != ovs_q);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      div_q    <= DIV_RST;
      frac_q   <= '0;
      ovs_q    <= OVS_RST;
      div_p    <= '0;
      frac_p   <= '0;
      ovs_p    <= '0;
      cfg_pend <= 1'b0;
    end else if (apply) begin
      div_q    <= div_n;
      frac_q   <= frac_n;
      ovs_q    <= ovs_n;
      cfg_pend <= 1'b0;
    end else if (cfg_load) begin
      div_p    <= div_in;
      frac_p   <= frac_in;
      ovs_p    <= ovs_in;
      cfg_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt        <= '0;
      acc        <= '0;
      ovs_cnt    <= '0;
      sio_ce_ovs <= 1'b0;
      sio_ce     <= 1'b0;
    end else if (!en) begin
      cnt        <= '0;
      acc        <= '0;
      ovs_cnt    <= '0;
      sio_ce_ovs <= 1'b0;
      sio_ce     <= 1'b0;
    end else begin
      sio_ce_ovs <= tick;
      sio_ce     <= tick && ovs_last;
      if (tick) begin
        cnt <= '0;
        acc <= sum[FRAC_W-1:0];
      end else begin
        cnt <= cnt + CNT_ONE;
      end
      // New ratio starts counting from zero.
      if (ovs_chg) begin
        ovs_cnt <= '0;
      end else if (tick) begin
        ovs_cnt <= ovs_last ? 4'd0 : ovs_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sasc_brg_prog.sv
// Bench for sasc_brg_prog: directed spacing checks plus random
// config/enable traffic against a tick-scheduling reference model.
module tb_sasc_brg_prog;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_load = 1'b0;
  logic [15:0] div_in = '0;
  logic [3:0]  frac_in = '0;
  logic [1:0]  ovs_in = '0;
  logic        cfg_pend;
  logic        sio_ce_ovs;
  logic        sio_ce;

  int compared = 0;
  int mismatched = 0;

  // Reference model: active/pending config, edges since last tick,
  // trim accumulator, ticks since ratio start, predicted outputs.
  int m_div, m_frac, m_ovs;
  int p_div, p_frac, p_ovs;
  bit m_pend;
  int m_el, m_acc, m_ticks;
  bit m_o, m_c;

  sasc_brg_prog dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .en         (en),
    .cfg_load   (cfg_load),
    .div_in     (div_in),
    .frac_in    (frac_in),
    .ovs_in     (ovs_in),
    .cfg_pend   (cfg_pend),
    .sio_ce_ovs (sio_ce_ovs),
    .sio_ce     (sio_ce)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic int ratio(input int o);
    if (o == 0) return 4;
    if (o == 1) return 8;
    return 16;
  endfunction

  task automatic model_reset();
    m_div = 103; m_frac = 0; m_ovs = 0;
    p_div = 0; p_frac = 0; p_ovs = 0;
    m_pend = 0;
    m_el = 0; m_acc = 0; m_ticks = 0;
    m_o = 0; m_c = 0;
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    bit tick;
    bit app;
    int per;
    int nd, nf, no;
    tick = 0;
    if (en) begin
      per = m_div + 1 + (((m_acc + m_frac) >= 16) ? 1 : 0);
      tick = (m_el + 1 == per);
    end
    app = tick || !en;
    m_o = tick;
    m_c = tick && ((m_ticks % ratio(m_ovs)) == ratio(m_ovs) - 1);
    if (!en) begin
      m_el = 0; m_acc = 0; m_ticks = 0;
    end else if (tick) begin
      m_el = 0;
      m_acc = (m_acc + m_frac) % 16;
      m_ticks++;
    end else begin
      m_el++;
    end
    if (app) begin
      nd = m_div; nf = m_frac; no = m_ovs;
      if (cfg_load) begin
        nd = int'(div_in); nf = int'(frac_in); no = int'(ovs_in);
      end else if (m_pend) begin
        nd = p_div; nf = p_frac; no = p_ovs;
      end
      if (no != m_ovs) m_ticks = 0;
      m_div = nd; m_frac = nf; m_ovs = no;
      m_pend = 0;
    end else if (cfg_load) begin
      p_div = int'(div_in); p_frac = int'(frac_in); p_ovs = int'(ovs_in);
      m_pend = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check("ovs", 32'(sio_ce_ovs), 32'(m_o));
    check("ce", 32'(sio_ce), 32'(m_c));
    check("pend", 32'(cfg_pend), 32'(m_pend));
    cfg_load = 1'b0;
  endtask

  task automatic load(input int d, input int f, input int o);
    cfg_load = 1'b1;
    div_in = 16'(d);
    frac_in = 4'(f);
    ovs_in = 2'(o);
  endtask

  task automatic meas_ovs(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!sio_ce_ovs && n < 5000);
  endtask

  task automatic meas_ce(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!sio_ce && n < 5000);
  endtask

  initial begin
    int n;
    int sp[4];
    model_reset();
    #2;
    check("rst_ovs", 32'(sio_ce_ovs), 0);
    check("rst_ce", 32'(sio_ce), 0);
    check("rst_pend", 32'(cfg_pend), 0);
    #10 arst_n = 1'b1;
    cyc();

    // Default 104 / 416 spacing.
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      meas_ovs(n);
      check("def_ovs_sp", n, 104);
    end
    check("def_ce_4th", 32'(sio_ce), 1);
    cyc();
    check("def_width", 32'(sio_ce_ovs), 0);
    meas_ce(n);
    check("def_ce_sp", n + 1, 416);
    check("def_ce_coin", 32'(sio_ce_ovs), 1);

    // Fractional trim loaded while idle.
    en = 1'b0;
    load(9, 8, 0);
    cyc();
    check("frac_pend", 32'(cfg_pend), 0);
    en = 1'b1;
    sp[0] = 10; sp[1] = 11; sp[2] = 10; sp[3] = 11;
    for (int i = 0; i < 4; i++) begin
      meas_ovs(n);
      check("frac_sp", n, sp[i]);
    end
    meas_ce(n);
    check("frac_ce_sp", n, 42);

    // Mid-period reconfig to div=0, x16.
    en = 1'b0;
    load(103, 0, 0);
    cyc();
    en = 1'b1;
    meas_ovs(n);
    check("mid_first", n, 104);
    repeat (50) cyc();
    load(0, 0, 2);
    cyc();
    check("mid_pend", 32'(cfg_pend), 1);
    meas_ovs(n);
    check("mid_period", n + 51, 104);
    check("mid_applied", 32'(cfg_pend), 0);
    meas_ce(n);
    check("x16_first_ce", n, 16);
    for (int i = 0; i < 3; i++) begin
      meas_ovs(n);
      check("div0_ovs", n, 1);
    end
    meas_ce(n);
    check("x16_ce_sp", n + 3, 16);

    // Last cfg_load before wrap wins.
    en = 1'b0;
    load(103, 0, 0);
    cyc();
    en = 1'b1;
    cyc();
    load(20, 0, 0);
    cyc();
    check("lww_pend1", 32'(cfg_pend), 1);
    load(30, 0, 0);
    cyc();
    check("lww_pend2", 32'(cfg_pend), 1);
    meas_ovs(n);
    check("lww_applied", 32'(cfg_pend), 0);
    for (int i = 0; i < 2; i++) begin
      meas_ovs(n);
      check("lww_sp", n, 31);
    end

    // One-cycle enable drop restarts phase.
    en = 1'b0;
    load(103, 0, 0);
    cyc();
    en = 1'b1;
    meas_ovs(n);
    check("en_first", n, 104);
    repeat (40) cyc();
    en = 1'b0;
    cyc();
    check("en_drop_ovs", 32'(sio_ce_ovs), 0);
    check("en_drop_ce", 32'(sio_ce), 0);
    en = 1'b1;
    meas_ovs(n);
    check("en_restart", n, 104);

    // Async reset with a pending config.
    repeat (30) cyc();
    load(50, 3, 1);
    cyc();
    check("rst_mid_pend", 32'(cfg_pend), 1);
    #2 arst_n = 1'b0;
    #1;
    check("rst_mid_ovs", 32'(sio_ce_ovs), 0);
    check("rst_mid_ce", 32'(sio_ce), 0);
    check("rst_mid_pclr", 32'(cfg_pend), 0);
    model_reset();
    @(posedge clk);
    #1 arst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      meas_ovs(n);
      check("rst_ovs_sp", n, 104);
    end
    meas_ce(n);
    check("rst_ce_part", n, 208);
    meas_ce(n);
    check("rst_ce_sp", n, 416);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 99) < 4)
        load(int'($urandom_range(0, 12)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
